// File: rtl/bp_fe_tournament_bht.sv
// bp_fe_tournament_bht
//   Tournament branch-direction predictor for the FE stage. A gshare global
//   PHT and a local (per-PC history) PHT are arbitrated by a chooser table
//   indexed by the global history register. After reset the tables are
//   cleared by hardware, one index per cycle, before the predictor runs.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   RESET  | just out of reset, tables untrusted
//   CLEAR  | writing clear values, one index per cycle
//   RUN    | predicting and training; held until rst
//
// Ports
//   clock, rst        clock, asynchronous active-high reset
//   init_done_o       tables cleared, predictor running
//   r_v_i, r_pc_i     prediction request and fetch PC
//   pred_v_o          prediction valid, one cycle after r_v_i
//   pred_taken_o      final predicted direction
//   pred_meta_o       {ghist, lhist, gpred, lpred, choose_g} snapshot
//   spec_v_i          speculative GHR shift, spec_taken_i is shifted in
//   w_v_i, w_ready_o  update handshake
//   w_pc_i, w_taken_i resolved branch PC and direction
//   w_meta_i          metadata returned from the original prediction
module bp_fe_tournament_bht #(
    parameter int PC_W      = 39,
    parameter int GHIST_W   = 12,
    parameter int LHT_IDX_W = 10,
    parameter int LHIST_W   = 10,
    parameter int CTR_W     = 3,
    localparam int META_W   = GHIST_W + LHIST_W + 3
) (
    input  logic              clock,
    input  logic              rst,
    output logic              init_done_o,
    input  logic              r_v_i,
    input  logic [PC_W-1:0]   r_pc_i,
    output logic              pred_v_o,
    output logic              pred_taken_o,
    output logic [META_W-1:0] pred_meta_o,
    input  logic              spec_v_i,
    input  logic              spec_taken_i,
    input  logic              w_v_i,
    output logic              w_ready_o,
    input  logic [PC_W-1:0]   w_pc_i,
    input  logic              w_taken_i,
    input  logic [META_W-1:0] w_meta_i
);

    localparam int CLR_W = (GHIST_W >= LHIST_W)
                         ? ((GHIST_W >= LHT_IDX_W) ? GHIST_W : LHT_IDX_W)
                         : ((LHIST_W >= LHT_IDX_W) ? LHIST_W : LHT_IDX_W);
    localparam int G_DEPTH   = 1 << GHIST_W;
    localparam int L_DEPTH   = 1 << LHIST_W;
    localparam int LHT_DEPTH = 1 << LHT_IDX_W;
    localparam logic [CTR_W-1:0] CTR_WEAK = {1'b1, {(CTR_W-1){1'b0}}};

    typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_RUN} state_t;

    state_t             state;
    logic [CLR_W-1:0]   clr_cnt;
    logic               init_done;
    logic [GHIST_W-1:0] ghr;

    logic [CTR_W-1:0]   gpht    [G_DEPTH];
    logic [CTR_W-1:0]   chooser [G_DEPTH];
    logic [CTR_W-1:0]   lpht    [L_DEPTH];
    logic [LHIST_W-1:0] lht     [LHT_DEPTH];

    function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    function automatic logic [CTR_W-1:0] sat_dec(input logic [CTR_W-1:0] c);
        return (c == '0) ? c : c - 1'b1;
    endfunction

    // Read side (combinational lookup, registered below)
    logic [GHIST_W-1:0]   r_gidx;
    logic [LHIST_W-1:0]   r_lhist;
    logic                 r_gpred, r_lpred, r_choose;
    logic                 r_final;

    assign r_gidx   = ghr ^ r_pc_i[2 +: GHIST_W];
    assign r_lhist  = lht[r_pc_i[2 +: LHT_IDX_W]];
    assign r_gpred  = gpht[r_gidx][CTR_W-1];
    assign r_lpred  = lpht[r_lhist][CTR_W-1];
    assign r_choose = chooser[ghr][CTR_W-1];
    assign r_final  = (r_gpred == r_lpred) ? r_gpred : (r_choose ? r_gpred : r_lpred);

    // Update side
    logic                 w_fire;
    logic [GHIST_W-1:0]   w_ghist;
    logic [LHIST_W-1:0]   w_lhist;
    logic                 w_gpred, w_lpred, w_choose, w_final, w_mispredict;
    logic [GHIST_W-1:0]   w_gidx;
    logic [LHT_IDX_W-1:0] w_lht_idx;
    logic [LHIST_W-1:0]   w_lhist_cur;

    assign w_fire       = w_v_i & init_done;
    assign w_ghist      = w_meta_i[META_W-1 -: GHIST_W];
    assign w_lhist      = w_meta_i[3 +: LHIST_W];
    assign w_gpred      = w_meta_i[2];
    assign w_lpred      = w_meta_i[1];
    assign w_choose     = w_meta_i[0];
    assign w_gidx       = w_ghist ^ w_pc_i[2 +: GHIST_W];
    assign w_lht_idx    = w_pc_i[2 +: LHT_IDX_W];
    assign w_lhist_cur  = lht[w_lht_idx];
    // Rebuild the prediction that was actually made to detect a mispredict
    assign w_final      = (w_gpred == w_lpred) ? w_gpred : (w_choose ? w_gpred : w_lpred);
    assign w_mispredict = w_final != w_taken_i;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{r_pc_i, w_pc_i};

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state     <= ST_RESET;
            clr_cnt   <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_RESET: begin
                    state   <= ST_CLEAR;
                    clr_cnt <= '0;
                end
                ST_CLEAR: begin
                    if (clr_cnt == '1) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // Table storage carries no reset; contents are rebuilt by the clear pass.
    // Reads above see the pre-update value on a same-cycle collision.
    always_ff @(posedge clock) begin
        if (state == ST_CLEAR) begin
            if ((clr_cnt >> GHIST_W) == '0) begin
                gpht[clr_cnt[GHIST_W-1:0]]    <= CTR_WEAK;
                chooser[clr_cnt[GHIST_W-1:0]] <= CTR_WEAK;
            end
            if ((clr_cnt >> LHIST_W) == '0)
                lpht[clr_cnt[LHIST_W-1:0]] <= CTR_WEAK;
            if ((clr_cnt >> LHT_IDX_W) == '0)
                lht[clr_cnt[LHT_IDX_W-1:0]] <= '0;
        end else if (w_fire) begin
            gpht[w_gidx]    <= w_taken_i ? sat_inc(gpht[w_gidx]) : sat_dec(gpht[w_gidx]);
            lpht[w_lhist]   <= w_taken_i ? sat_inc(lpht[w_lhist]) : sat_dec(lpht[w_lhist]);
            lht[w_lht_idx]  <= {w_lhist_cur[LHIST_W-2:0], w_taken_i};
            if (w_gpred != w_lpred)
                chooser[w_ghist] <= (w_gpred == w_taken_i) ? sat_inc(chooser[w_ghist])
                                                            : sat_dec(chooser[w_ghist]);
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            ghr          <= '0;
            pred_v_o     <= 1'b0;
            pred_taken_o <= 1'b0;
            pred_meta_o  <= '0;
        end else begin
            pred_v_o <= 1'b0;
            if (state == ST_RUN) begin
                if (r_v_i) begin
                    pred_v_o     <= 1'b1;
                    pred_taken_o <= r_final;
                    pred_meta_o  <= {ghr, r_lhist, r_gpred, r_lpred, r_choose};
                end
                // Repair wins over a same-cycle speculative shift
                if (w_fire && w_mispredict)
                    ghr <= {w_ghist[GHIST_W-2:0], w_taken_i};
                else if (spec_v_i)
                    ghr <= {ghr[GHIST_W-2:0], spec_taken_i};
            end else begin
                ghr <= '0;
            end
        end
    end

    assign init_done_o = init_done;
    assign w_ready_o   = init_done;

endmodule

// File: tb/tb_bp_fe_tournament_bht.sv
module tb_bp_fe_tournament_bht;

    localparam int PC_W    = 39;
    localparam int GHIST_W = 12;
    localparam int LHIST_W = 10;
    localparam int META_W  = GHIST_W + LHIST_W + 3;
    localparam int CLEAR_CYCLES = 4097;

    logic              clock;
    logic              rst;
    logic              init_done_o;
    logic              r_v_i;
    logic [PC_W-1:0]   r_pc_i;
    logic              pred_v_o;
    logic              pred_taken_o;
    logic [META_W-1:0] pred_meta_o;
    logic              spec_v_i;
    logic              spec_taken_i;
    logic              w_v_i;
    logic              w_ready_o;
    logic [PC_W-1:0]   w_pc_i;
    logic              w_taken_i;
    logic [META_W-1:0] w_meta_i;

    int errors = 0;
    int checks = 0;

    bp_fe_tournament_bht dut (
        .clock(clock), .rst(rst), .init_done_o(init_done_o),
        .r_v_i(r_v_i), .r_pc_i(r_pc_i),
        .pred_v_o(pred_v_o), .pred_taken_o(pred_taken_o), .pred_meta_o(pred_meta_o),
        .spec_v_i(spec_v_i), .spec_taken_i(spec_taken_i),
        .w_v_i(w_v_i), .w_ready_o(w_ready_o), .w_pc_i(w_pc_i),
        .w_taken_i(w_taken_i), .w_meta_i(w_meta_i)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [META_W-1:0] mk_meta(input logic [GHIST_W-1:0] gh,
                                                  input logic [LHIST_W-1:0] lh,
                                                  input logic g, input logic l, input logic c);
        return {gh, lh, g, l, c};
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Called just after rst is released; returns edges until init_done_o, -1 on timeout
    task automatic wait_init(output int cycles);
        cycles = 0;
        while (!init_done_o && cycles < 5000) begin
            tick();
            cycles++;
        end
        if (!init_done_o) cycles = -1;
    endtask

    task automatic init_dut(output int cycles);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_init(cycles);
    endtask

    task automatic do_read(input logic [PC_W-1:0] pc);
        r_v_i  = 1'b1;
        r_pc_i = pc;
        tick();
        r_v_i  = 1'b0;
    endtask

    task automatic do_update(input logic [PC_W-1:0] pc, input logic taken,
                             input logic [META_W-1:0] meta);
        w_v_i     = 1'b1;
        w_pc_i    = pc;
        w_taken_i = taken;
        w_meta_i  = meta;
        tick();
        w_v_i     = 1'b0;
    endtask

    task automatic test_reset;
        int cycles;
        int pred_seen;
        tick();
        tick();
        checks++; if (init_done_o !== 1'b0) begin errors++; $display("FAIL rst_init_done: got %0b expected 0", init_done_o); end
        checks++; if (w_ready_o !== 1'b0) begin errors++; $display("FAIL rst_w_ready: got %0b expected 0", w_ready_o); end
        checks++; if (pred_v_o !== 1'b0) begin errors++; $display("FAIL rst_pred_v: got %0b expected 0", pred_v_o); end
        checks++; if (pred_taken_o !== 1'b0) begin errors++; $display("FAIL rst_pred_taken: got %0b expected 0", pred_taken_o); end
        checks++; if (pred_meta_o !== '0) begin errors++; $display("FAIL rst_pred_meta: got %0h expected 0", pred_meta_o); end
        // Requests and spec shifts during clear must be ignored
        r_v_i = 1'b1; r_pc_i = 39'h1000; spec_v_i = 1'b1; spec_taken_i = 1'b1;
        rst = 1'b0;
        cycles = 0; pred_seen = 0;
        while (!init_done_o && cycles < 5000) begin
            tick();
            cycles++;
            if (pred_v_o) pred_seen++;
        end
        r_v_i = 1'b0; spec_v_i = 1'b0; spec_taken_i = 1'b0;
        checks++; if (cycles !== CLEAR_CYCLES) begin errors++; $display("FAIL clear_cycles: got %0d expected %0d", cycles, CLEAR_CYCLES); end
        checks++; if (pred_seen !== 0) begin errors++; $display("FAIL clear_pred_v: got %0d valid cycles expected 0", pred_seen); end
        checks++; if (w_ready_o !== 1'b1) begin errors++; $display("FAIL run_w_ready: got %0b expected 1", w_ready_o); end
        do_read(39'h1000);
        checks++; if (pred_v_o !== 1'b1) begin errors++; $display("FAIL dflt_pred_v: got %0b expected 1", pred_v_o); end
        checks++; if (pred_taken_o !== 1'b1) begin errors++; $display("FAIL dflt_taken: got %0b expected 1", pred_taken_o); end
        checks++; if (pred_meta_o !== 25'h7) begin errors++; $display("FAIL dflt_meta: got %0h expected 7", pred_meta_o); end
        tick();
        checks++; if (pred_v_o !== 1'b0) begin errors++; $display("FAIL idle_pred_v: got %0b expected 0", pred_v_o); end
        checks++; if (pred_meta_o !== 25'h7) begin errors++; $display("FAIL hold_meta: got %0h expected 7", pred_meta_o); end
    endtask

    task automatic test_saturate;
        int cycles;
        logic [META_W-1:0] meta_n, meta_t;
        meta_n = mk_meta(12'h0, 10'h0, 1'b0, 1'b0, 1'b1);
        meta_t = mk_meta(12'h0, 10'h0, 1'b1, 1'b1, 1'b1);
        init_dut(cycles);
        checks++; if (cycles !== CLEAR_CYCLES) begin errors++; $display("FAIL sat_init: got %0d expected %0d", cycles, CLEAR_CYCLES); end
        do_update(39'h1000, 1'b0, meta_n);
        do_read(39'h1000);
        checks++; if (pred_taken_o !== 1'b0) begin errors++; $display("FAIL sat_first_n: got %0b expected 0", pred_taken_o); end
        checks++; if (pred_meta_o !== 25'h1) begin errors++; $display("FAIL sat_first_meta: got %0h expected 1", pred_meta_o); end
        for (int i = 0; i < 5; i++) do_update(39'h1000, 1'b0, meta_n);
        do_read(39'h1000);
        checks++; if (pred_taken_o !== 1'b0) begin errors++; $display("FAIL sat_six_n: got %0b expected 0", pred_taken_o); end
        // From a floor of 0 three takens reach only 3
        for (int i = 0; i < 3; i++) do_update(39'h1000, 1'b1, meta_t);
        do_read(39'h1000);
        checks++; if (pred_taken_o !== 1'b0) begin errors++; $display("FAIL sat_floor: got %0b expected 0", pred_taken_o); end
        checks++; if (pred_meta_o !== 25'h3B) begin errors++; $display("FAIL sat_floor_meta: got %0h expected 3b", pred_meta_o); end
        do_update(39'h1000, 1'b1, meta_t);
        do_read(39'h1000);
        checks++; if (pred_taken_o !== 1'b1) begin errors++; $display("FAIL sat_recover: got %0b expected 1", pred_taken_o); end
        checks++; if (pred_meta_o !== 25'h7F) begin errors++; $display("FAIL sat_recover_meta: got %0h expected 7f", pred_meta_o); end
    endtask

    task automatic test_alternating;
        int cycles;
        logic [LHIST_W-1:0] h;
        logic t;
        init_dut(cycles);
        checks++; if (cycles !== CLEAR_CYCLES) begin errors++; $display("FAIL alt_init: got %0d expected %0d", cycles, CLEAR_CYCLES); end
        h = '0;
        for (int k = 0; k < 64; k++) begin
            t = (k % 2 == 0);
            // gshare always leans taken, local is right, chooser votes local
            do_update(39'h1000, t, mk_meta(12'h0, h, 1'b1, t, 1'b0));
            h = {h[LHIST_W-2:0], t};
        end
        do_read(39'h1000);
        checks++; if (pred_taken_o !== 1'b1) begin errors++; $display("FAIL alt_pred_t: got %0b expected 1", pred_taken_o); end
        checks++; if (pred_meta_o !== 25'h1556) begin errors++; $display("FAIL alt_meta_2aa: got %0h expected 1556", pred_meta_o); end
        do_update(39'h1000, 1'b1, mk_meta(12'h0, 10'h2AA, 1'b1, 1'b1, 1'b0));
        do_read(39'h1000);
        checks++; if (pred_taken_o !== 1'b0) begin errors++; $display("FAIL alt_pred_n: got %0b expected 0", pred_taken_o); end
        checks++; if (pred_meta_o !== 25'hAAC) begin errors++; $display("FAIL alt_meta_155: got %0h expected aac", pred_meta_o); end
    endtask

    task automatic test_spec_repair;
        int cycles;
        init_dut(cycles);
        checks++; if (cycles !== CLEAR_CYCLES) begin errors++; $display("FAIL spec_init: got %0d expected %0d", cycles, CLEAR_CYCLES); end
        spec_v_i = 1'b1; spec_taken_i = 1'b1;
        tick(); tick(); tick();
        spec_v_i = 1'b0;
        do_read(39'h0);
        checks++; if (pred_meta_o !== 25'hE007) begin errors++; $display("FAIL spec_ghr7: got %0h expected e007", pred_meta_o); end
        checks++; if (pred_taken_o !== 1'b1) begin errors++; $display("FAIL spec_taken: got %0b expected 1", pred_taken_o); end
        spec_v_i = 1'b1; spec_taken_i = 1'b0;
        do_update(39'h2000, 1'b1, mk_meta(12'h005, 10'h0, 1'b0, 1'b0, 1'b1));
        spec_v_i = 1'b0;
        do_read(39'h0);
        checks++; if (pred_meta_o !== 25'h1600F) begin errors++; $display("FAIL repair_ghr: got %0h expected 1600f", pred_meta_o); end
        spec_v_i = 1'b1; spec_taken_i = 1'b1;
        do_update(39'h2000, 1'b1, mk_meta(12'h0, 10'h1, 1'b1, 1'b1, 1'b1));
        spec_v_i = 1'b0;
        do_read(39'h0);
        checks++; if (pred_meta_o !== 25'h2E01F) begin errors++; $display("FAIL no_repair_shift: got %0h expected 2e01f", pred_meta_o); end
    endtask

    task automatic test_collision;
        int cycles;
        init_dut(cycles);
        checks++; if (cycles !== CLEAR_CYCLES) begin errors++; $display("FAIL col_init: got %0d expected %0d", cycles, CLEAR_CYCLES); end
        do_update(39'h1000, 1'b0, mk_meta(12'h0, 10'h0, 1'b0, 1'b0, 1'b1));
        r_v_i = 1'b1; r_pc_i = 39'h1000;
        w_v_i = 1'b1; w_pc_i = 39'h1000; w_taken_i = 1'b1;
        w_meta_i = mk_meta(12'h0, 10'h0, 1'b1, 1'b1, 1'b1);
        checks++; if (w_ready_o !== 1'b1) begin errors++; $display("FAIL col_ready: got %0b expected 1", w_ready_o); end
        tick();
        r_v_i = 1'b0; w_v_i = 1'b0;
        checks++; if (pred_taken_o !== 1'b0) begin errors++; $display("FAIL col_old_value: got %0b expected 0", pred_taken_o); end
        checks++; if (pred_meta_o !== 25'h1) begin errors++; $display("FAIL col_old_meta: got %0h expected 1", pred_meta_o); end
        do_read(39'h1000);
        checks++; if (pred_taken_o !== 1'b1) begin errors++; $display("FAIL col_update_kept: got %0b expected 1", pred_taken_o); end
        checks++; if (pred_meta_o !== 25'hF) begin errors++; $display("FAIL col_new_meta: got %0h expected f", pred_meta_o); end
    endtask

    task automatic test_reset_mid;
        int cycles;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        rst = 1'b1;
        #1;
        checks++; if (init_done_o !== 1'b0) begin errors++; $display("FAIL midclr_init_done: got %0b expected 0", init_done_o); end
        tick();
        rst = 1'b0;
        wait_init(cycles);
        checks++; if (cycles !== CLEAR_CYCLES) begin errors++; $display("FAIL midclr_recount: got %0d expected %0d", cycles, CLEAR_CYCLES); end
        spec_v_i = 1'b1; spec_taken_i = 1'b1;
        tick(); tick(); tick();
        spec_v_i = 1'b0;
        do_update(39'h1000, 1'b0, mk_meta(12'h0, 10'h0, 1'b0, 1'b0, 1'b1));
        do_update(39'h1000, 1'b0, mk_meta(12'h0, 10'h0, 1'b0, 1'b0, 1'b1));
        #3;
        rst = 1'b1;
        #1;
        checks++; if (init_done_o !== 1'b0) begin errors++; $display("FAIL midrun_init_done: got %0b expected 0", init_done_o); end
        checks++; if (w_ready_o !== 1'b0) begin errors++; $display("FAIL midrun_w_ready: got %0b expected 0", w_ready_o); end
        tick();
        rst = 1'b0;
        wait_init(cycles);
        checks++; if (cycles !== CLEAR_CYCLES) begin errors++; $display("FAIL midrun_recount: got %0d expected %0d", cycles, CLEAR_CYCLES); end
        do_read(39'h1000);
        checks++; if (pred_taken_o !== 1'b1) begin errors++; $display("FAIL midrun_dflt_taken: got %0b expected 1", pred_taken_o); end
        checks++; if (pred_meta_o !== 25'h7) begin errors++; $display("FAIL midrun_dflt_meta: got %0h expected 7", pred_meta_o); end
    endtask

    initial begin
        rst = 1'b1;
        r_v_i = 1'b0; r_pc_i = '0;
        spec_v_i = 1'b0; spec_taken_i = 1'b0;
        w_v_i = 1'b0; w_pc_i = '0; w_taken_i = 1'b0; w_meta_i = '0;
        test_reset();
        test_saturate();
        test_alternating();
        test_spec_repair();
        test_collision();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
